// File: rtl/psg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psg_pkg
//  Description : Shared constants, types and helpers for the PSG audio path.
//  Revision    : 1.0 - initial release
// ============================================================================
package psg_pkg;

   localparam int PSG_DW    = 10;
   localparam int PSG_OUT_W = 16;

   localparam logic signed [PSG_OUT_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [PSG_OUT_W-1:0] SAT_MIN = 16'sh8000;

   // Ring RAM clear sequencer: sweep all entries to zero, then serve normally
   typedef enum logic [0:0] {
      RAM_SWEEP = 1'b0,
      RAM_READY = 1'b1
   } ram_state_t;

   // Clamp a wide signed value into the signed output range
   function automatic logic signed [PSG_OUT_W-1:0] sat_out(input logic signed [31:0] v);
      logic signed [PSG_OUT_W-1:0] r;
      if (v > 32'(SAT_MAX))
         r = SAT_MAX;
      else if (v < 32'(SAT_MIN))
         r = SAT_MIN;
      else
         r = v[PSG_OUT_W-1:0];
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/psg_dc_block_if.sv
`default_nettype none
// ============================================================================
//  Module      : psg_dc_block_if
//  Description : Sample stream into the DC blocker and filtered stream out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface psg_dc_block_if import psg_pkg::*; #(
   parameter int DW = PSG_DW
) ();

   logic                        cen;
   logic [DW-1:0]               din;
   logic signed [PSG_OUT_W-1:0] dout;
   logic                        dout_valid;

   // Producer of raw samples / consumer of filtered samples
   modport master (
      output cen,
      output din,
      input  dout,
      input  dout_valid
   );

   // The DC blocker itself
   modport slave (
      input  cen,
      input  din,
      output dout,
      output dout_valid
   );

endinterface
`default_nettype wire

// File: rtl/psg_ring_ram.sv
`default_nettype none
// ============================================================================
//  Module      : psg_ring_ram
//  Description : 2^AW x DW sample store, read-before-write on one port, with
//                a one-entry-per-cycle clear sweep after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module psg_ring_ram import psg_pkg::*; #(
   parameter int DW = PSG_DW,
   parameter int AW = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   input  wire logic          we,
   input  wire logic [AW-1:0] addr,
   input  wire logic [DW-1:0] wdata,
   output logic      [DW-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   ram_state_t    state, state_nx;
   logic [AW-1:0] clr_ptr;
   logic          clr_en;
   logic          clr_hit;

   // The writer's pointer never runs ahead of the sweep pointer (both start at
   // zero, the sweep advances every cycle). So the only not-yet-cleared entry
   // a write can touch is the one the sweep is on right now: that read is
   // forced to zero and the sweep skips clearing over the fresh sample.
   assign clr_hit = clr_en && (addr == clr_ptr);

   // Sweep state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= RAM_SWEEP;
      else
         state <= state_nx;
   end

   // Sweep sequencing: walk every entry once, then go idle
   always_comb begin
      state_nx = state;
      clr_en   = 1'b0;
      case (state)
         RAM_SWEEP: begin
            clr_en = 1'b1;
            if (clr_ptr == AW'(DEPTH - 1))
               state_nx = RAM_READY;
         end
         RAM_READY: begin
            state_nx = RAM_READY;
         end
         default: begin
            state_nx = RAM_SWEEP;
         end
      endcase
   end

   // Sweep pointer, held at zero during reset
   always_ff @(posedge clk) begin
      if (rst)
         clr_ptr <= '0;
      else if (clr_en)
         clr_ptr <= clr_ptr + 1'b1;
   end

   // Storage: old value out, new value in, sweep clear on a different entry
   always_ff @(posedge clk) begin
      if (we) begin
         rdata     <= clr_hit ? '0 : mem[addr];
         mem[addr] <= wdata;
      end
      if (clr_en && !(we && clr_hit))
         mem[clr_ptr] <= '0;
   end

endmodule
`default_nettype wire

// File: rtl/psg_dc_block.sv
`default_nettype none
// ============================================================================
//  Module      : psg_dc_block
//  Description : Removes the moving average of the last 2^LOG_WIN samples
//                from the PSG mix, applies gain, saturates to signed 16 bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module psg_dc_block import psg_pkg::*; #(
   parameter int DW         = PSG_DW,
   parameter int LOG_WIN    = 4,
   parameter int GAIN_SHIFT = 5
) (
   input wire logic       clk,
   input wire logic       rst,
   psg_dc_block_if.slave  sif
);

   localparam int SW = DW + LOG_WIN;
   localparam int EW = 32;

   logic [LOG_WIN-1:0]   wp;
   logic                 we;
   logic [DW-1:0]        old;
   logic [DW-1:0]        x1, x2;
   logic                 v1, v2, v3;
   logic [SW-1:0]        sum;
   logic [DW-1:0]        mean;
   logic signed [DW:0]   diff, diff_nx;
   logic signed [EW-1:0] shifted;

   assign we = sif.cen & ~rst;

   psg_ring_ram #(
      .DW (DW),
      .AW (LOG_WIN)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .addr  (wp),
      .wdata (sif.din),
      .rdata (old)
   );

   // S1: capture the sample and advance the write pointer (RAM reads old)
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         x1 <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= sif.cen;
         if (sif.cen) begin
            x1 <= sif.din;
            wp <= wp + 1'b1;
         end
      end
   end

   // S2: running sum swaps the evicted sample for the new one
   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
         x2  <= '0;
         v2  <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            sum <= sum + SW'(x1) - SW'(old);
            x2  <= x1;
         end
      end
   end

   assign mean    = sum[SW-1:LOG_WIN];
   assign diff_nx = $signed({1'b0, x2}) - $signed({1'b0, mean});

   // S3: difference between the sample and the window mean including it
   always_ff @(posedge clk) begin
      if (rst) begin
         diff <= '0;
         v3   <= 1'b0;
      end else begin
         v3 <= v2;
         if (v2)
            diff <= diff_nx;
      end
   end

   assign shifted = $signed({{(EW-DW-1){diff[DW]}}, diff}) <<< GAIN_SHIFT;

   // S4: gain, clamp and present; dout holds between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         sif.dout       <= '0;
         sif.dout_valid <= 1'b0;
      end else begin
         sif.dout_valid <= v3;
         if (v3)
            sif.dout <= sat_out(shifted);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_psg_dc_block.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psg_dc_block
//  Description : Directed bench for psg_dc_block at gain shifts 5 and 6.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psg_dc_block;
   import psg_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   int n_checks = 0;
   int n_fail   = 0;

   int q5[$];
   int q6[$];
   int qc5[$];

   psg_dc_block_if #(.DW(10)) if5 ();
   psg_dc_block_if #(.DW(10)) if6 ();

   psg_dc_block #(.DW(10), .LOG_WIN(4), .GAIN_SHIFT(5)) dut5 (
      .clk (clk),
      .rst (rst),
      .sif (if5)
   );

   psg_dc_block #(.DW(10), .LOG_WIN(4), .GAIN_SHIFT(6)) dut6 (
      .clk (clk),
      .rst (rst),
      .sif (if6)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Collect every output pulse
   always @(negedge clk) begin
      if (if5.dout_valid) begin
         q5.push_back(int'(if5.dout));
         qc5.push_back(cyc);
      end
      if (if6.dout_valid)
         q6.push_back(int'(if6.dout));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int din;
      int exp5;
      int exp6;
   } vec_t;

   localparam int NV = 38;
   vec_t tbl[NV];

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic c, input int d);
      if5.cen = c;
      if6.cen = c;
      if5.din = 10'(d);
      if6.din = 10'(d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic drain_clear();
      repeat (6) @(negedge clk);
      q5.delete();
      q6.delete();
      qc5.delete();
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 0);

      // ---- reset held two cycles with cen toggling ----
      @(negedge clk);
      check("rst_valid_c0", int'(if5.dout_valid), 0);
      check("rst_dout_c0", int'(if5.dout), 0);
      drive(1'b1, 300);
      @(negedge clk);
      check("rst_valid_c1", int'(if5.dout_valid), 0);
      check("rst_dout_c1", int'(if5.dout), 0);
      rst = 1'b0;
      drive(1'b0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("post_rst_valid_%0d", i), int'(if5.dout_valid), 0);
         check($sformatf("post_rst_dout_%0d", i), int'(if5.dout), 0);
      end

      // ---- first sample latency, during the clear sweep ----
      drive(1'b1, 512);
      @(negedge clk);             // edge k
      drive(1'b0, 0);
      check("lat_valid_k", int'(if5.dout_valid), 0);
      @(negedge clk);             // k+1
      check("lat_valid_k1", int'(if5.dout_valid), 0);
      @(negedge clk);             // k+2
      check("lat_valid_k2", int'(if5.dout_valid), 0);
      @(negedge clk);             // k+3
      check("lat_valid_k3", int'(if5.dout_valid), 1);
      check("lat_dout5_k3", int'(if5.dout), 15360);
      check("lat_dout6_k3", int'(if6.dout), 30720);
      @(negedge clk);
      check("lat_valid_k4", int'(if5.dout_valid), 0);
      check("lat_hold_k4", int'(if5.dout), 15360);

      // ---- table: 20 x 512 cold start, then step to 256 ----
      // Cold start, sample n: mean = 32n, diff = 512 - 32n until the window fills.
      // Step, m-th 256: mean = 512 - 16m, diff = 16m - 256 until it settles.
      for (int n = 1; n <= 20; n++) begin
         tbl[n-1].din  = 512;
         tbl[n-1].exp5 = (n <= 16) ? (16384 - 1024 * n) : 0;
         tbl[n-1].exp6 = (n <= 16) ? (32768 - 2048 * n) : 0;
      end
      for (int m = 1; m <= 18; m++) begin
         tbl[19+m].din  = 256;
         tbl[19+m].exp5 = (m <= 16) ? (512 * m - 8192) : 0;
         tbl[19+m].exp6 = (m <= 16) ? (1024 * m - 16384) : 0;
      end

      do_reset();
      drain_clear();
      for (int i = 0; i < NV; i++) begin
         drive(1'b1, tbl[i].din);
         @(negedge clk);
      end
      drive(1'b0, 0);
      repeat (6) @(negedge clk);
      check("tbl_count5", q5.size(), NV);
      check("tbl_count6", q6.size(), NV);
      if (qc5.size() == NV)
         check("tbl_back_to_back", qc5[NV-1] - qc5[0], NV - 1);
      for (int i = 0; i < NV; i++) begin
         if (i < q5.size())
            check($sformatf("tbl5_%0d", i), q5[i], tbl[i].exp5);
         if (i < q6.size())
            check($sformatf("tbl6_%0d", i), q6[i], tbl[i].exp6);
      end

      // ---- saturation: 17 x 1023 then a single 0 ----
      do_reset();
      drain_clear();
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, (i < 17) ? 1023 : 0);
         @(negedge clk);
      end
      drive(1'b0, 0);
      repeat (6) @(negedge clk);
      check("sat_count6", q6.size(), 18);
      check("sat_count5", q5.size(), 18);
      if (q6.size() == 18) begin
         check("sat6_first_pos", q6[0], 32767);
         check("sat6_last_neg", q6[17], -32768);
      end
      if (q5.size() == 18) begin
         check("sat5_first", q5[0], 30720);
         check("sat5_last", q5[17], -30688);
      end

      // ---- reset one cycle after a sample ----
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 100);
         @(negedge clk);
      end
      drive(1'b0, 0);
      drain_clear();
      check("mid_pre_dout", int'(if5.dout), 2208);
      drive(1'b1, 512);
      @(negedge clk);             // edge k: sample accepted
      drive(1'b0, 0);
      rst = 1'b1;
      @(negedge clk);             // edge k+1: reset
      rst = 1'b0;
      check("mid_rst_dout", int'(if5.dout), 0);
      repeat (6) @(negedge clk);
      check("mid_discard_count", q5.size(), 0);
      drive(1'b1, 512);
      @(negedge clk);
      drive(1'b0, 0);
      repeat (6) @(negedge clk);
      check("mid_next_count", q5.size(), 1);
      if (q5.size() >= 1)
         check("mid_next_dout", q5[0], 15360);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/psg_dc_block.md
# psg_dc_block

Streaming DC-removal stage placed directly downstream of the PSG core. It takes the core's 10-bit unsigned mixed `sound` and its per-sample strobe, and subtracts a moving average over the last 2^LOG_WIN samples. It then applies a fixed gain and saturates, producing a signed 16-bit sample with a one-cycle valid pulse for the audio mixer/DAC path.

## Interface
- `DW`, 10: input sample width (unsigned).
- `LOG_WIN`, 4: log2 of averaging window (window = 16 samples).
- `GAIN_SHIFT`, 5: left shift applied to the DC-free difference.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cen`  in  1  sample strobe, driven by the PSG `sample` output; may be high on consecutive cycles.
- `din`  in  DW  unsigned sample, valid when `cen`=1.
- `dout`  out  16  signed DC-free sample.
- `dout_valid`  out  1  one-cycle pulse marking a new `dout`.

## Operation
- Ring buffer of 2^LOG_WIN entries, DW bits each, with write pointer `wp` (LOG_WIN bits, wraps 15→0).
- Running sum `sum`, DW+LOG_WIN bits, unsigned. It never overflows because it always equals the sum of the buffer contents.
- Per accepted sample x, in three pipeline stages:
  - **S1 (cen cycle):** capture x. Read old = buf[wp], write buf[wp] = x, then wp++.
  - **S2:** sum = sum + x − old.
  - **S3:** compute mean = sum >> LOG_WIN, using the updated sum (the window includes x). Compute diff = x − mean as a (DW+1)-bit signed value, then shifted = diff << GAIN_SHIFT. `dout` = shifted clamped to [−32768, 32767], and `dout_valid` = 1.
- Within the window, buffer, sum and mean are computed exactly with no rounding; truncation happens only in `>> LOG_WIN`.
- After reset the buffer behaves as all-zero, so the mean ramps up over the first 2^LOG_WIN samples (cold start). Do not special-case this.
- Input held constant at value v: once 2^LOG_WIN samples have been taken, mean = v and `dout` = 0.

## Timing
- Reset values:
  - `dout` = 0, `dout_valid` = 0, `sum` = 0, `wp` = 0.
  - All buffer entries read as 0. Clear them with a 2^LOG_WIN-cycle sweep after `rst` falls, or use a per-entry valid bitmap.
  - If a sweep is used, `cen` arriving during the sweep is still accepted and the sample must read old = 0.
- Latency: `cen` sampled high at edge k gives `dout`/`dout_valid` updated at edge k+3, visible for the cycle after it.
- Throughput: one sample per clock. Back-to-back `cen` produce back-to-back `dout_valid` in input order.
- `dout_valid` is high for exactly one cycle per accepted sample. `dout` holds its value between pulses.
- `cen`=0: no state change apart from pipeline drain.
- `rst` mid-operation has priority over everything:
  - in-flight samples are discarded and no `dout_valid` is emitted for them;
  - the state returns to the reset values on the next edge.
- Sample on the wrap (wp = 15): it overwrites entry 15, and the next sample reads entry 0.

## Structure
- Shared package `psg_pkg`:
  - constants PSG_DW = 10 and PSG_OUT_W = 16;
  - saturation limits SAT_MAX = 16'sh7FFF and SAT_MIN = 16'sh8000.
- One sub-module, `psg_ring_ram`: 2^LOG_WIN × DW, with synchronous read-before-write on the same address and a synchronous clear sweep. Pointer, sum and output pipeline stay in `psg_dc_block`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `cen` toggling → `dout` = 0 and `dout_valid` = 0 throughout and for 3 cycles after release.
- **First sample after reset:** `din` = 512 → `dout` = 15360 at edge k+3. (sum = 512, mean = 32, diff = 480, 480 << 5.)
- **Constant input:** 20 back-to-back samples of 512 → 20 consecutive `dout_valid` pulses, decreasing monotonically. Samples 16..20 give `dout` = 0.
- **Step:** after settling at 512, step to 256 → first `dout` = (256 − 496) << 5 = −7680, then it decays to 0 after 16 samples.
- **Saturation** (GAIN_SHIFT = 6): first sample `din` = 1023 → mean = 63, diff = 960 → `dout` = 32767. With settled input 1023, `din` = 0 → diff = −959, shifted = −61376 → `dout` = −32768.
- **Reset mid-stream:** `rst` one cycle after a `cen` → no `dout_valid` for that sample. The next sample, 512, gives `dout` = 15360 (cold-start value).
